// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter.
// Arbiter FSM states, port owner encoding and default timeout.
package mem_port_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_XFER
    } arb_state_t;

    // Bit position of each owner matches its slot in the request vector.
    typedef enum logic {
        OWNER_C,
        OWNER_D
    } owner_t;

    localparam int ARB_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU port, debug port, arbiter and memory.
// slave: arbiter side; master: requesters + memory side.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic          c_gnt;
    logic          c_done;
    logic [DW-1:0] c_rdata;
    logic          c_stall;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_done;
    logic [DW-1:0] d_rdata;

    logic          err;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_ready, mem_rdata,
        output c_gnt, c_done, c_rdata, c_stall,
        output d_gnt, d_done, d_rdata,
        output err,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        output d_req, d_we, d_addr, d_wdata,
        output mem_ready, mem_rdata,
        input  c_gnt, c_done, c_rdata, c_stall,
        input  d_gnt, d_done, d_rdata,
        input  err,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker.
// Ports: req[1:0] (0=CPU, 1=debug), last -> valid, pick.
module mem_port_arbiter_rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last,
    output logic       valid,
    output owner_t     pick
);

    always_comb begin
        valid = |req;
        pick  = OWNER_C;
        unique case (req)
            2'b01:   pick = OWNER_C;
            2'b10:   pick = OWNER_D;
            // Tie: whoever was not served last wins.
            2'b11:   pick = (last == OWNER_C) ? OWNER_D : OWNER_C;
            default: pick = OWNER_C;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between the CPU and debug ports.
// Ports: clk, reset (async, active-high), bus (slave modport).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT,
    parameter int TW      = 5
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

    localparam bit            TO_EN   = (TIMEOUT != 0);
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    arb_state_t    state_q, state_d;
    owner_t        owner_q, owner_d;
    owner_t        last_q, last_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          cmd_we_q;
    logic [AW-1:0] cmd_addr_q;
    logic [DW-1:0] cmd_wdata_q;

    logic          pk_valid;
    owner_t        pk_pick;
    logic          load;
    logic          gnt;
    logic          fin;
    logic          to_err;
    logic [DW-1:0] rd;

    mem_port_arbiter_rr_pick2 u_pick (
        .req   ({bus.d_req, bus.c_req}),
        .last  (last_q),
        .valid (pk_valid),
        .pick  (pk_pick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWNER_C;
            last_q      <= OWNER_D;
            cnt_q       <= '0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            if (load) begin
                if (pk_pick == OWNER_C) begin
                    cmd_we_q    <= bus.c_we;
                    cmd_addr_q  <= bus.c_addr;
                    cmd_wdata_q <= bus.c_wdata;
                end else begin
                    cmd_we_q    <= bus.d_we;
                    cmd_addr_q  <= bus.d_addr;
                    cmd_wdata_q <= bus.d_wdata;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        gnt     = 1'b0;
        fin     = 1'b0;
        to_err  = 1'b0;
        rd      = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (pk_valid) begin
                    gnt     = 1'b1;
                    load    = 1'b1;
                    owner_d = pk_pick;
                    last_d  = pk_pick;
                    cnt_d   = '0;
                    state_d = ARB_XFER;
                end
            end
            ARB_XFER: begin
                // mem_ready beats a coinciding timeout.
                if (bus.mem_ready) begin
                    fin     = 1'b1;
                    rd      = cmd_we_q ? '0 : bus.mem_rdata;
                    cnt_d   = '0;
                    state_d = ARB_IDLE;
                end else if (TO_EN && cnt_q == TO_LAST) begin
                    fin     = 1'b1;
                    to_err  = 1'b1;
                    cnt_d   = '0;
                    state_d = ARB_IDLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Grants come straight from the request inputs, so mask them in reset.
    assign bus.c_gnt   = gnt & ~reset & (pk_pick == OWNER_C);
    assign bus.d_gnt   = gnt & ~reset & (pk_pick == OWNER_D);
    assign bus.c_done  = fin & (owner_q == OWNER_C);
    assign bus.d_done  = fin & (owner_q == OWNER_D);
    assign bus.c_rdata = (owner_q == OWNER_C) ? rd : '0;
    assign bus.d_rdata = (owner_q == OWNER_D) ? rd : '0;
    assign bus.c_stall = bus.c_req & ~bus.c_done;
    assign bus.err     = to_err;

    assign bus.mem_req   = (state_q == ARB_XFER);
    assign bus.mem_we    = cmd_we_q;
    assign bus.mem_addr  = cmd_addr_q;
    assign bus.mem_wdata = cmd_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (TIMEOUT = 4).
// Stimulus pushes expected completions; a monitor checks every done.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(
        .AW      (32),
        .DW      (32),
        .TIMEOUT (4),
        .TW      (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clr_in();
        bus.c_req     = 0;
        bus.c_we      = 0;
        bus.c_addr    = 0;
        bus.c_wdata   = 0;
        bus.d_req     = 0;
        bus.d_we      = 0;
        bus.d_addr    = 0;
        bus.d_wdata   = 0;
        bus.mem_ready = 0;
        bus.mem_rdata = 0;
    endtask

    task automatic do_reset();
        nxt();
        reset = 1;
        clr_in();
        smp();
        chk("rst_mem_req", 32'(bus.mem_req), 0);
        nxt();
        reset = 0;
    endtask

    // Monitor: every done is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.err && !(bus.c_done || bus.d_done))
                chk("err_without_done", 32'(bus.err), 0);
            if (!bus.c_done)
                chk("c_rdata_idle", bus.c_rdata, 0);
            if (!bus.d_done)
                chk("d_rdata_idle", bus.d_rdata, 0);
            if (bus.c_done || bus.d_done) begin
                chk("single_done", 32'(bus.c_done & bus.d_done), 0);
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'(1), 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("done_port", 32'(bus.d_done), 32'(e.port));
                    chk("done_rdata",
                        bus.d_done ? bus.d_rdata : bus.c_rdata, e.rdata);
                    chk("done_err", 32'(bus.err), 32'(e.err));
                end
            end
        end
    end

    initial begin
        reset = 1;
        clr_in();
        smp();
        chk("rst_mem_req", 32'(bus.mem_req), 0);
        chk("rst_c_gnt", 32'(bus.c_gnt), 0);
        chk("rst_d_gnt", 32'(bus.d_gnt), 0);
        chk("rst_c_done", 32'(bus.c_done), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        nxt();
        reset = 0;

        // CPU read, memory ready immediately
        bus.c_req     = 1;
        bus.c_addr    = 32'h10;
        bus.mem_ready = 1;
        bus.mem_rdata = 32'h1234_5678;
        smp();
        chk("t1_c_gnt", 32'(bus.c_gnt), 1);
        chk("t1_d_gnt", 32'(bus.d_gnt), 0);
        chk("t1_mem_req0", 32'(bus.mem_req), 0);
        chk("t1_stall0", 32'(bus.c_stall), 1);
        q.push_back('{port: 1'b0, rdata: 32'h1234_5678, err: 1'b0});
        nxt();
        bus.c_addr = 32'h99;
        smp();
        chk("t1_mem_req1", 32'(bus.mem_req), 1);
        chk("t1_mem_addr", bus.mem_addr, 32'h10);
        chk("t1_mem_we", 32'(bus.mem_we), 0);
        chk("t1_c_done", 32'(bus.c_done), 1);
        chk("t1_stall1", 32'(bus.c_stall), 0);
        nxt();
        bus.c_req = 0;
        smp();
        chk("t1_stall2", 32'(bus.c_stall), 0);
        chk("t1_gnt2", 32'(bus.c_gnt), 0);
        chk("t1_mem_req2", 32'(bus.mem_req), 0);

        // Continuous contention: C, D, C, D
        do_reset();
        bus.c_req     = 1;
        bus.d_req     = 1;
        bus.c_addr    = 32'h100;
        bus.d_addr    = 32'h200;
        bus.mem_ready = 1;
        for (int i = 0; i < 4; i++) begin
            logic p;
            p = (i % 2) == 1;
            if (i > 0) nxt();
            bus.mem_rdata = 32'hA000_0000 + 32'(i);
            smp();
            chk("t2_c_gnt", 32'(bus.c_gnt), 32'(!p));
            chk("t2_d_gnt", 32'(bus.d_gnt), 32'(p));
            q.push_back('{port: p, rdata: 32'hA000_0000 + 32'(i), err: 1'b0});
            nxt();
            smp();
            chk("t2_mem_addr", bus.mem_addr, p ? 32'h200 : 32'h100);
            chk("t2_no_gnt_xfer", 32'(bus.c_gnt | bus.d_gnt), 0);
        end
        nxt();
        bus.c_req     = 0;
        bus.d_req     = 0;
        bus.mem_ready = 0;
        smp();

        // Debug write, memory ready on the 4th transfer cycle
        nxt();
        bus.d_req     = 1;
        bus.d_we      = 1;
        bus.d_addr    = 32'h40;
        bus.d_wdata   = 32'hCAFE_F00D;
        bus.mem_rdata = 32'hDEAD_BEEF;
        smp();
        chk("t3_d_gnt", 32'(bus.d_gnt), 1);
        q.push_back('{port: 1'b1, rdata: 32'h0, err: 1'b0});
        for (int k = 1; k <= 4; k++) begin
            nxt();
            bus.d_req     = 0;
            bus.d_wdata   = 0;
            bus.mem_ready = (k == 4);
            smp();
            chk("t3_mem_req", 32'(bus.mem_req), 1);
            chk("t3_mem_we", 32'(bus.mem_we), 1);
            chk("t3_mem_wdata", bus.mem_wdata, 32'hCAFE_F00D);
            chk("t3_mem_addr", bus.mem_addr, 32'h40);
            chk("t3_d_done", 32'(bus.d_done), 32'(k == 4));
        end
        nxt();
        bus.mem_ready = 0;
        bus.d_we      = 0;
        smp();
        chk("t3_mem_req_end", 32'(bus.mem_req), 0);

        // Timeout with memory never ready
        nxt();
        bus.c_req     = 1;
        bus.c_addr    = 32'h80;
        bus.mem_rdata = 32'h5555_5555;
        smp();
        chk("t4_c_gnt", 32'(bus.c_gnt), 1);
        q.push_back('{port: 1'b0, rdata: 32'h0, err: 1'b1});
        for (int k = 1; k <= 4; k++) begin
            nxt();
            bus.c_req = 0;
            smp();
            chk("t4_mem_req", 32'(bus.mem_req), 1);
            chk("t4_c_done", 32'(bus.c_done), 32'(k == 4));
            chk("t4_err", 32'(bus.err), 32'(k == 4));
        end
        nxt();
        smp();
        chk("t4_mem_req_end", 32'(bus.mem_req), 0);
        chk("t4_done_end", 32'(bus.c_done), 0);

        // Reset in the 2nd transfer cycle
        nxt();
        bus.c_req  = 1;
        bus.c_addr = 32'h20;
        smp();
        chk("t5_c_gnt", 32'(bus.c_gnt), 1);
        nxt();
        smp();
        chk("t5_xfer1", 32'(bus.mem_req), 1);
        nxt();
        bus.d_req = 1;
        reset     = 1;
        smp();
        chk("t5_rst_mem_req", 32'(bus.mem_req), 0);
        chk("t5_rst_c_done", 32'(bus.c_done), 0);
        chk("t5_rst_d_done", 32'(bus.d_done), 0);
        chk("t5_rst_err", 32'(bus.err), 0);
        chk("t5_rst_c_gnt", 32'(bus.c_gnt), 0);
        nxt();
        reset         = 0;
        bus.mem_ready = 1;
        bus.mem_rdata = 32'h77;
        smp();
        chk("t5_tie_c_gnt", 32'(bus.c_gnt), 1);
        chk("t5_tie_d_gnt", 32'(bus.d_gnt), 0);
        q.push_back('{port: 1'b0, rdata: 32'h77, err: 1'b0});
        nxt();
        bus.c_req = 0;
        bus.d_req = 0;
        smp();
        chk("t5_mem_addr", bus.mem_addr, 32'h20);
        nxt();
        smp();
        chk("t5_no_d_gnt", 32'(bus.d_gnt), 0);
        chk("t5_mem_req_end", 32'(bus.mem_req), 0);

        // mem_ready in idle is ignored
        for (int k = 0; k < 2; k++) begin
            nxt();
            bus.mem_ready = (k == 0);
            bus.mem_rdata = 32'hFFFF;
            smp();
            chk("t6_mem_req", 32'(bus.mem_req), 0);
            chk("t6_err", 32'(bus.err), 0);
            chk("t6_done", 32'(bus.c_done | bus.d_done), 0);
        end
        nxt();
        bus.d_req     = 1;
        bus.d_we      = 0;
        bus.d_addr    = 32'h44;
        bus.mem_ready = 1;
        bus.mem_rdata = 32'h0BAD_0BAD;
        smp();
        chk("t6_d_gnt", 32'(bus.d_gnt), 1);
        q.push_back('{port: 1'b1, rdata: 32'h0BAD_0BAD, err: 1'b0});
        nxt();
        bus.d_req = 0;
        smp();
        chk("t6_mem_addr", bus.mem_addr, 32'h44);
        nxt();
        bus.mem_ready = 0;
        smp();
        chk("queue_empty", 32'(q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
